tlk2711_tx_dma_cmd_gen: RTL and testbench
=========================================

TLK2711_TX_DMA_CMD_GEN -- requirements
Module: tlk2711_tx_dma_cmd_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32, DDR byte-address width.
- BTT_W, 23, bytes-to-transfer field width.
- CHUNK_BYTES, 1024, maximum bytes per DMA command; power of two, 64..4096.
- MAX_OUTSTD, 4, maximum issued but uncompleted commands; 1..15.
- CMD_W, ADDR_W+40, DMA command width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, the single clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_soft_rst, in, 1, synchronous active-high clear, equivalent to reset.
- i_reg_wen / i_reg_waddr / i_reg_wdata, in, 1/12/32, register write port.
- i_reg_ren / i_reg_raddr, in, 1/12, register read request.
- o_reg_rdata / o_reg_valid, out, 32/1, read data and its strobe.
- o_dma_rdcmd_data / o_dma_rdcmd_valid / i_dma_rdcmd_ready, out/out/in, CMD_W/1/1, DMA read command stream.
- i_dma_xfer_done, in, 1, one-cycle pulse per completed command.
- o_packet_len / o_packet_num, out, 16/16, latched frame geometry for the TX framer.
- o_send_start, out, 1, one-cycle pulse for the TX framer.
- o_busy / o_frame_done, out, 1/1, status level and end-of-frame pulse.

Function
REQ-003 Registers:
- 0x04 CTRL: bit0 START and bit1 ABORT, write-1-pulse, self-clearing.
- 0x08 PKT: [15:0] PKT_LEN in bytes, [31:16] PKT_NUM.
- 0x10 BASE: DDR start address.
- 0x14 STATUS, read-only: bit0 busy, bit1 done (sticky), bit2 err (sticky), [31:16] completed-command count.
REQ-004 Reads: o_reg_valid rises exactly 1 cycle after i_reg_ren. Unmapped addresses return 0.
REQ-005 Writes to PKT and BASE while busy are ignored.
REQ-006 FSM states: IDLE, CALC, ISSUE, WAIT, DRAIN, DONE.
REQ-007 IDLE to CALC on START. In CALC:
- latch remaining = PKT_LEN*PKT_NUM as a 32-bit product;
- latch cur_addr = BASE;
- clear the counters;
- pulse o_send_start one cycle after START.
REQ-008 If the product is 0, CALC goes to DONE: no command is issued, err is set, done is set.
REQ-009 Chunk length = min(remaining, CHUNK_BYTES, 4096 - cur_addr[11:0]). No command crosses a 4 KB boundary.
REQ-010 Command format, MSB to LSB:
- 4'h0;
- tag[3:0] = issued count mod 16;
- cur_addr;
- DRR = 0;
- EOF = 1 only on the final chunk;
- DSA = 6'd0;
- type = 1;
- BTT = chunk zero-extended to BTT_W.
REQ-011 In ISSUE, o_dma_rdcmd_valid is held and the data is stable until i_dma_rdcmd_ready. On acceptance:
- cur_addr += chunk;
- remaining -= chunk;
- outstanding += 1;
- valid drops the next cycle unless a further command is issued immediately.
REQ-012 Go from ISSUE to WAIT when remaining = 0, or when outstanding = MAX_OUTSTD after acceptance. Go from WAIT back to ISSUE when remaining > 0 and outstanding < MAX_OUTSTD.
REQ-013 Every i_dma_xfer_done decrements outstanding and increments the completed count. Acceptance and done in the same cycle leave outstanding unchanged.
REQ-014 A done pulse with outstanding = 0 sets err and is otherwise ignored.
REQ-015 WAIT goes to DONE when remaining = 0 and outstanding = 0. DONE pulses o_frame_done for one cycle, sets done, and returns to IDLE.
REQ-016 ABORT in CALC, ISSUE or WAIT:
- no new command is issued; a command already valid but not accepted is withdrawn the next cycle;
- go to DRAIN until outstanding = 0, then IDLE, with done not set.
REQ-017 START while busy is ignored.
REQ-018 A new START clears the done and err bits.
REQ-019 o_busy = 1 in every state except IDLE.

Reset
REQ-020 On i_rst_n low (asynchronous) or i_soft_rst high (synchronous), all outputs and registers are 0 and the FSM is IDLE. This includes o_dma_rdcmd_valid, o_send_start, o_frame_done and o_reg_valid.
REQ-021 Reset mid-frame discards all state. Done pulses arriving after reset leave err clear until the next START.

Verification
REQ-022 PKT_LEN=820, PKT_NUM=4, BASE=0x1000, CHUNK_BYTES=1024, ready always high -> BTTs 1024,1024,1024,208; addresses 0x1000,0x1400,0x1800,0x1C00; EOF only on the last; o_frame_done after 4 done pulses.
REQ-023 BASE=0x0F80, PKT_LEN=256, PKT_NUM=1 -> two commands: BTT 128 at 0x0F80, then BTT 128 at 0x1000.
REQ-024 MAX_OUTSTD=2, 8 chunks, done pulses withheld -> exactly 2 commands issued, then valid stays low; each done pulse releases exactly one more command.
REQ-025 Ready held low for 10 cycles -> valid and data stable throughout; a done pulse coinciding with acceptance leaves outstanding unchanged.
REQ-026 PKT_NUM=0 with START -> no command issued; STATUS = 0x00000006 with busy low.
REQ-027 ABORT after 1 of 4 commands -> no further valid; IDLE after 1 done pulse; done bit 0. Async reset mid-ISSUE -> valid low immediately.

Source files
------------

// File: rtl/tlk2711_tx_dma_cmd_gen.sv
// TLK2711 TX DMA command generator: splits a PKT_LEN*PKT_NUM byte frame at BASE
// into DMA read commands of at most CHUNK_BYTES that never cross a 4 KB page.
module tlk2711_tx_dma_cmd_gen #(
  parameter int ADDR_W      = 32,
  parameter int BTT_W       = 23,
  parameter int CHUNK_BYTES = 1024,
  parameter int MAX_OUTSTD  = 4,
  parameter int CMD_W       = ADDR_W + 40
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_soft_rst,
  input  logic              i_reg_wen,
  input  logic [11:0]       i_reg_waddr,
  input  logic [31:0]       i_reg_wdata,
  input  logic              i_reg_ren,
  input  logic [11:0]       i_reg_raddr,
  output logic [31:0]       o_reg_rdata,
  output logic              o_reg_valid,
  output logic [CMD_W-1:0]  o_dma_rdcmd_data,
  output logic              o_dma_rdcmd_valid,
  input  logic              i_dma_rdcmd_ready,
  input  logic              i_dma_xfer_done,
  output logic [15:0]       o_packet_len,
  output logic [15:0]       o_packet_num,
  output logic              o_send_start,
  output logic              o_busy,
  output logic              o_frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t             state_q;
  logic [15:0]        pkt_len_q, pkt_num_q, out_len_q, out_num_q;
  logic [ADDR_W-1:0]  base_q, cur_addr_q;
  logic [31:0]        remaining_q;
  logic [12:0]        chunk_q;
  logic [3:0]         outstd_q, tag_q;
  logic [15:0]        cmpl_cnt_q;
  logic               done_bit_q, err_bit_q;
  logic [CMD_W-1:0]   cmd_q;
  logic               cmd_vld_q, send_start_q, frame_done_q, reg_valid_q;
  logic [31:0]        reg_rdata_q;

  // Largest legal chunk: limited by bytes left, CHUNK_BYTES and the 4 KB page end.
  function automatic logic [12:0] chunk_of(input logic [31:0] rem, input logic [ADDR_W-1:0] addr);
    logic [12:0] lim;
    lim = 13'd4096 - {1'b0, addr[11:0]};
    if (13'(CHUNK_BYTES) < lim) lim = 13'(CHUNK_BYTES);
    if (rem < {19'd0, lim}) lim = rem[12:0];
    return lim;
  endfunction

  function automatic logic [CMD_W-1:0] cmd_of(input logic [3:0] tag, input logic [ADDR_W-1:0] addr,
                                              input logic eof, input logic [12:0] len);
    return CMD_W'({4'h0, tag, addr, 1'b0, eof, 6'd0, 1'b1, BTT_W'(len)});
  endfunction

  logic               start, abort, acc, done_ok;
  logic [3:0]         out_n;
  logic [31:0]        product, rem_after;
  logic [ADDR_W-1:0]  addr_after;
  logic [12:0]        calc_chunk, next_chunk, wait_chunk;
  logic [31:0]        rd_mux;

  assign start      = i_reg_wen && (i_reg_waddr == 12'h004) && i_reg_wdata[0];
  assign abort      = i_reg_wen && (i_reg_waddr == 12'h004) && i_reg_wdata[1];
  assign acc        = cmd_vld_q && i_dma_rdcmd_ready;
  assign done_ok    = i_dma_xfer_done && (outstd_q != 4'd0);
  assign out_n      = outstd_q + {3'd0, acc} - {3'd0, done_ok};
  assign product    = {16'd0, pkt_len_q} * {16'd0, pkt_num_q};
  assign rem_after  = remaining_q - {19'd0, chunk_q};
  assign addr_after = cur_addr_q + ADDR_W'(chunk_q);
  assign calc_chunk = chunk_of(product, base_q);
  assign next_chunk = chunk_of(rem_after, addr_after);
  assign wait_chunk = chunk_of(remaining_q, cur_addr_q);

  always_comb begin
    rd_mux = 32'd0;
    case (i_reg_raddr)
      12'h008: rd_mux = {pkt_num_q, pkt_len_q};
      12'h010: rd_mux = 32'(base_q);
      12'h014: rd_mux = {cmpl_cnt_q, 13'd0, err_bit_q, done_bit_q, (state_q != S_IDLE)};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      pkt_len_q    <= '0;
      pkt_num_q    <= '0;
      out_len_q    <= '0;
      out_num_q    <= '0;
      base_q       <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      chunk_q      <= '0;
      outstd_q     <= '0;
      tag_q        <= '0;
      cmpl_cnt_q   <= '0;
      done_bit_q   <= 1'b0;
      err_bit_q    <= 1'b0;
      cmd_q        <= '0;
      cmd_vld_q    <= 1'b0;
      send_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      reg_valid_q  <= 1'b0;
      reg_rdata_q  <= '0;
    end else if (i_soft_rst) begin
      state_q      <= S_IDLE;
      pkt_len_q    <= '0;
      pkt_num_q    <= '0;
      out_len_q    <= '0;
      out_num_q    <= '0;
      base_q       <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      chunk_q      <= '0;
      outstd_q     <= '0;
      tag_q        <= '0;
      cmpl_cnt_q   <= '0;
      done_bit_q   <= 1'b0;
      err_bit_q    <= 1'b0;
      cmd_q        <= '0;
      cmd_vld_q    <= 1'b0;
      send_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      reg_valid_q  <= 1'b0;
      reg_rdata_q  <= '0;
    end else begin
      reg_valid_q  <= i_reg_ren;
      reg_rdata_q  <= i_reg_ren ? rd_mux : 32'd0;
      send_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      outstd_q     <= out_n;
      cmpl_cnt_q   <= cmpl_cnt_q + {15'd0, done_ok};

      if (i_reg_wen && (state_q == S_IDLE)) begin
        if (i_reg_waddr == 12'h008) begin
          pkt_len_q <= i_reg_wdata[15:0];
          pkt_num_q <= i_reg_wdata[31:16];
        end
        if (i_reg_waddr == 12'h010) base_q <= ADDR_W'(i_reg_wdata);
      end

      // Stray completions are errors only while a frame is in flight.
      if (i_dma_xfer_done && (outstd_q == 4'd0) && (state_q != S_IDLE)) err_bit_q <= 1'b1;

      if (acc) begin
        cur_addr_q  <= addr_after;
        remaining_q <= rem_after;
        tag_q       <= tag_q + 4'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_CALC;
            send_start_q <= 1'b1;
            done_bit_q   <= 1'b0;
            err_bit_q    <= 1'b0;
            out_len_q    <= pkt_len_q;
            out_num_q    <= pkt_num_q;
          end
        end
        S_CALC: begin
          remaining_q <= product;
          cur_addr_q  <= base_q;
          tag_q       <= '0;
          cmpl_cnt_q  <= '0;
          if (abort) begin
            state_q <= S_DRAIN;
          end else if (product == 32'd0) begin
            state_q      <= S_DONE;
            err_bit_q    <= 1'b1;
            done_bit_q   <= 1'b1;
            frame_done_q <= 1'b1;
          end else begin
            state_q   <= S_ISSUE;
            cmd_q     <= cmd_of(4'd0, base_q, product == {19'd0, calc_chunk}, calc_chunk);
            chunk_q   <= calc_chunk;
            cmd_vld_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            cmd_vld_q <= 1'b0;
            state_q   <= S_DRAIN;
          end else if (acc) begin
            if ((rem_after == 32'd0) || (out_n == 4'(MAX_OUTSTD))) begin
              cmd_vld_q <= 1'b0;
              state_q   <= S_WAIT;
            end else begin
              cmd_q   <= cmd_of(tag_q + 4'd1, addr_after, rem_after == {19'd0, next_chunk}, next_chunk);
              chunk_q <= next_chunk;
            end
          end
        end
        S_WAIT: begin
          if (abort) begin
            state_q <= S_DRAIN;
          end else if ((remaining_q == 32'd0) && (out_n == 4'd0)) begin
            state_q      <= S_DONE;
            done_bit_q   <= 1'b1;
            frame_done_q <= 1'b1;
          end else if ((remaining_q != 32'd0) && (out_n < 4'(MAX_OUTSTD))) begin
            state_q   <= S_ISSUE;
            cmd_q     <= cmd_of(tag_q, cur_addr_q, remaining_q == {19'd0, wait_chunk}, wait_chunk);
            chunk_q   <= wait_chunk;
            cmd_vld_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_n == 4'd0) state_q <= S_IDLE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_reg_rdata       = reg_rdata_q;
  assign o_reg_valid       = reg_valid_q;
  assign o_dma_rdcmd_data  = cmd_q;
  assign o_dma_rdcmd_valid = cmd_vld_q;
  assign o_packet_len      = out_len_q;
  assign o_packet_num      = out_num_q;
  assign o_send_start      = send_start_q;
  assign o_busy            = (state_q != S_IDLE);
  assign o_frame_done      = frame_done_q;

endmodule

// File: tb/tb_tlk2711_tx_dma_cmd_gen.sv
// Directed bench for tlk2711_tx_dma_cmd_gen: register table, frame splitting,
// outstanding limit, back-pressure, zero-length, abort and reset corners.
module tb_tlk2711_tx_dma_cmd_gen;
  localparam int CW = 72;

  logic clk = 1'b0, rst_n = 1'b0, soft_rst = 1'b0;
  logic reg_wen = 1'b0, reg_ren = 1'b0;
  logic [11:0] reg_waddr = '0, reg_raddr = '0;
  logic [31:0] reg_wdata = '0, reg_rdata;
  logic reg_valid;
  logic [CW-1:0] cmd_data;
  logic cmd_valid, cmd_ready = 1'b0, xfer_done = 1'b0;
  logic [15:0] pkt_len, pkt_num;
  logic send_start, busy, frame_done;

  int total = 0, bad = 0, done_sent = 0;
  logic [CW-1:0] acc_q[$];

  typedef struct { logic wr; logic [11:0] addr; logic [31:0] data; logic [31:0] exp; } rv_t;
  typedef struct { logic [3:0] tag; logic [31:0] addr; logic eof; logic [22:0] btt; } cmd_t;

  tlk2711_tx_dma_cmd_gen #(.MAX_OUTSTD(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_soft_rst(soft_rst),
    .i_reg_wen(reg_wen), .i_reg_waddr(reg_waddr), .i_reg_wdata(reg_wdata),
    .i_reg_ren(reg_ren), .i_reg_raddr(reg_raddr),
    .o_reg_rdata(reg_rdata), .o_reg_valid(reg_valid),
    .o_dma_rdcmd_data(cmd_data), .o_dma_rdcmd_valid(cmd_valid), .i_dma_rdcmd_ready(cmd_ready),
    .i_dma_xfer_done(xfer_done),
    .o_packet_len(pkt_len), .o_packet_num(pkt_num),
    .o_send_start(send_start), .o_busy(busy), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && cmd_valid && cmd_ready) acc_q.push_back(cmd_data);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input cmd_t c);
    return {4'h0, c.tag, c.addr, 1'b0, c.eof, 6'd0, 1'b1, c.btt};
  endfunction

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    reg_wen = 1'b1; reg_waddr = a; reg_wdata = d;
    tick();
    reg_wen = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    reg_ren = 1'b1; reg_raddr = a;
    tick();
    reg_ren = 1'b0;
    chk({name, "_vld"}, CW'(reg_valid), 1);
    chk(name, CW'(reg_rdata), CW'(exp));
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      tick();
      if (cmd_valid) ok = 1;
    end
  endtask

  // Acts as the DMA engine: one completion per cycle for every accepted command.
  task automatic run_frame(input int max_cyc, output bit got, output int nd);
    got = 0; nd = 0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      if (done_sent < acc_q.size()) begin xfer_done = 1'b1; done_sent++; end
      tick();
      xfer_done = 1'b0;
      if (frame_done) begin got = 1; nd = done_sent; end
    end
  endtask

  initial begin
    rv_t  regs[8];
    cmd_t f1[4];
    cmd_t f2[2];
    cmd_t c;
    bit   ok, got;
    int   nd, unstable;
    logic [CW-1:0] cap;

    regs[0] = '{1'b0, 12'h014, 32'h0, 32'h0};
    regs[1] = '{1'b1, 12'h008, 32'h0004_0334, 32'h0};
    regs[2] = '{1'b0, 12'h008, 32'h0, 32'h0004_0334};
    regs[3] = '{1'b1, 12'h010, 32'h0000_1000, 32'h0};
    regs[4] = '{1'b0, 12'h010, 32'h0, 32'h0000_1000};
    regs[5] = '{1'b0, 12'h004, 32'h0, 32'h0};
    regs[6] = '{1'b0, 12'h00C, 32'h0, 32'h0};
    regs[7] = '{1'b0, 12'h7FC, 32'h0, 32'h0};
    f1[0] = '{4'd0, 32'h1000, 1'b0, 23'd1024};
    f1[1] = '{4'd1, 32'h1400, 1'b0, 23'd1024};
    f1[2] = '{4'd2, 32'h1800, 1'b0, 23'd1024};
    f1[3] = '{4'd3, 32'h1C00, 1'b1, 23'd208};
    f2[0] = '{4'd0, 32'h0F80, 1'b0, 23'd128};
    f2[1] = '{4'd1, 32'h1000, 1'b1, 23'd128};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", CW'(cmd_valid), 0);
    chk("rst_send_start", CW'(send_start), 0);
    chk("rst_frame_done", CW'(frame_done), 0);
    chk("rst_reg_valid", CW'(reg_valid), 0);
    chk("rst_busy", CW'(busy), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      if (regs[i].wr) wr(regs[i].addr, regs[i].data);
      else begin
        rd_chk($sformatf("reg_rd%0d", i), regs[i].addr, regs[i].exp);
        tick();
        chk($sformatf("reg_vld_drop%0d", i), CW'(reg_valid), 0);
      end
    end

    // 820 x 4 bytes from 0x1000
    cmd_ready = 1'b1; acc_q.delete(); done_sent = 0;
    wr(12'h004, 32'h1);
    chk("f1_send_start", CW'(send_start), 1);
    chk("f1_busy", CW'(busy), 1);
    chk("f1_pkt_len", CW'(pkt_len), 820);
    chk("f1_pkt_num", CW'(pkt_num), 4);
    tick();
    chk("f1_send_start_drop", CW'(send_start), 0);
    run_frame(200, got, nd);
    chk("f1_frame_done", CW'(got), 1);
    chk("f1_dones_at_fd", CW'(nd), 4);
    chk("f1_ncmd", CW'(acc_q.size()), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) chk($sformatf("f1_cmd%0d", i), acc_q[i], mk(f1[i]));
    tick();
    rd_chk("f1_status", 12'h014, 32'h0004_0002);

    // 4 KB crossing
    wr(12'h008, 32'h0001_0100);
    wr(12'h010, 32'h0000_0F80);
    acc_q.delete(); done_sent = 0;
    wr(12'h004, 32'h1);
    run_frame(200, got, nd);
    chk("f2_frame_done", CW'(got), 1);
    chk("f2_ncmd", CW'(acc_q.size()), 2);
    for (int i = 0; i < 2 && i < acc_q.size(); i++) chk($sformatf("f2_cmd%0d", i), acc_q[i], mk(f2[i]));
    tick();

    // Outstanding limit of 2 with completions withheld
    wr(12'h008, 32'h0008_0400);
    wr(12'h010, 32'h0);
    acc_q.delete(); done_sent = 0;
    wr(12'h004, 32'h1);
    repeat (20) tick();
    chk("lim_ncmd2", CW'(acc_q.size()), 2);
    chk("lim_valid_low2", CW'(cmd_valid), 0);
    wr(12'h008, 32'hFFFF_FFFF);
    for (int k = 3; k <= 4; k++) begin
      xfer_done = 1'b1; tick(); xfer_done = 1'b0;
      repeat (10) tick();
      chk($sformatf("lim_ncmd%0d", k), CW'(acc_q.size()), CW'(k));
      chk($sformatf("lim_valid_low%0d", k), CW'(cmd_valid), 0);
    end
    done_sent = 2;
    run_frame(400, got, nd);
    chk("lim_frame_done", CW'(got), 1);
    chk("lim_ncmd_total", CW'(acc_q.size()), 8);
    tick();
    rd_chk("busy_write_ignored", 12'h008, 32'h0008_0400);

    // Back-pressure, then acceptance coinciding with a completion
    wr(12'h008, 32'h0001_0800);
    wr(12'h010, 32'h0000_2000);
    cmd_ready = 1'b0; acc_q.delete();
    wr(12'h004, 32'h1);
    wait_valid(ok);
    chk("bp_valid_seen", CW'(ok), 1);
    cap = cmd_data;
    c = '{4'd0, 32'h2000, 1'b0, 23'd1024};
    chk("bp_cmd0", cap, mk(c));
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_valid !== 1'b1 || cmd_data !== cap) unstable++;
    end
    chk("bp_hold_unstable", CW'(unstable), 0);
    cmd_ready = 1'b1; tick();
    xfer_done = 1'b1; tick();
    cmd_ready = 1'b0; xfer_done = 1'b0;
    chk("bp_ncmd", CW'(acc_q.size()), 2);
    c = '{4'd1, 32'h2400, 1'b1, 23'd1024};
    if (acc_q.size() >= 2) chk("bp_cmd1", acc_q[1], mk(c));
    got = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (frame_done) got = 1; end
    chk("bp_no_early_done", CW'(got), 0);
    chk("bp_busy", CW'(busy), 1);
    rd_chk("bp_status_mid", 12'h014, 32'h0001_0001);
    xfer_done = 1'b1; tick(); xfer_done = 1'b0;
    chk("bp_frame_done", CW'(frame_done), 1);
    tick();
    rd_chk("bp_status_end", 12'h014, 32'h0002_0002);

    // Zero-length frame
    wr(12'h008, 32'h0000_0064);
    acc_q.delete(); cmd_ready = 1'b1;
    wr(12'h004, 32'h1);
    repeat (5) tick();
    chk("zero_ncmd", CW'(acc_q.size()), 0);
    chk("zero_busy", CW'(busy), 0);
    rd_chk("zero_status", 12'h014, 32'h0000_0006);

    // Abort after one accepted command
    wr(12'h008, 32'h0004_0400);
    wr(12'h010, 32'h0);
    cmd_ready = 1'b0; acc_q.delete();
    wr(12'h004, 32'h1);
    wait_valid(ok);
    chk("ab_valid_seen", CW'(ok), 1);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    chk("ab_ncmd1", CW'(acc_q.size()), 1);
    rd_chk("ab_status_cleared", 12'h014, 32'h0000_0001);
    wr(12'h004, 32'h2);
    chk("ab_withdrawn", CW'(cmd_valid), 0);
    chk("ab_busy_drain", CW'(busy), 1);
    cmd_ready = 1'b1;
    repeat (10) tick();
    chk("ab_no_more_cmd", CW'(acc_q.size()), 1);
    chk("ab_still_drain", CW'(busy), 1);
    xfer_done = 1'b1; tick(); xfer_done = 1'b0;
    chk("ab_idle", CW'(busy), 0);
    rd_chk("ab_status", 12'h014, 32'h0001_0000);
    cmd_ready = 1'b0;

    // Asynchronous reset mid-ISSUE
    wr(12'h004, 32'h1);
    wait_valid(ok);
    chk("ar_valid_seen", CW'(ok), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_low", CW'(cmd_valid), 0);
    chk("ar_busy_low", CW'(busy), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    xfer_done = 1'b1; tick(); xfer_done = 1'b0;
    rd_chk("ar_status", 12'h014, 32'h0);
    rd_chk("ar_pkt", 12'h008, 32'h0);

    // Synchronous soft reset mid-ISSUE
    wr(12'h008, 32'h0004_0400);
    wr(12'h004, 32'h1);
    wait_valid(ok);
    chk("sr_valid_seen", CW'(ok), 1);
    soft_rst = 1'b1; tick(); soft_rst = 1'b0;
    chk("sr_valid_low", CW'(cmd_valid), 0);
    chk("sr_busy_low", CW'(busy), 0);
    rd_chk("sr_pkt", 12'h008, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
